p_shfrot_issue: RTL and testbench

- Sequential issue/retire stage wrapped around the combinational packed shift/rotate unit (p_shfrot).
- Accepts packed shift/rotate requests from the instruction decode path over a valid/ready handshake, decodes the pack-width code and op, and selects and normalises the shift amount.
- Registers the decoded operands that drive p_shfrot, then captures p_shfrot's result into a response register with its own valid/ready handshake.
- Two-stage pipeline; full throughput under no backpressure.

---
 rtl/p_shfrot_issue.sv | 139 +++++++++++++
 tb/tb_p_shfrot_issue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/p_shfrot_issue.sv
// Two-stage issue/retire wrapper around the combinational packed shift/rotate unit.
// S1 registers the decoded operands for p_shfrot; S2 captures its result as the response.
module p_shfrot_issue #(
   parameter int SHAMT_SRC_W = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_imm,
   input  logic        req_use_imm,
   input  logic [2:0]  req_pw,
   input  logic [1:0]  req_op,
   output logic [31:0] shf_crs1,
   output logic [4:0]  shf_shamt,
   output logic [4:0]  shf_pw,
   output logic        shf_shift,
   output logic        shf_rotate,
   output logic        shf_left,
   output logic        shf_right,
   input  logic [31:0] shf_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_illegal
);

   localparam int AMT_W = (SHAMT_SRC_W > 5) ? SHAMT_SRC_W : 5;

   logic             s1_valid_q, s2_valid_q;
   logic [31:0]      crs1_q, result_q;
   logic [4:0]       shamt_q, pw_q;
   logic             shift_q, rotate_q, left_q, right_q;
   logic             s1_illegal_q, s2_illegal_q;

   logic             s2_free, s1_adv, accept;
   logic [AMT_W-1:0] amt;
   logic [4:0]       pw_d, mask, shamt_d;
   logic [2:0]       log_w;
   logic             illegal_d, too_big;
   logic [31:0]      crs1_d;

   assign s2_free   = !s2_valid_q | rsp_ready;
   assign s1_adv    = s1_valid_q & s2_free;
   assign req_ready = !s1_valid_q | s1_adv;
   assign accept    = req_valid & req_ready;

   always_comb begin
      amt = '0;
      if (req_use_imm) amt[4:0] = req_imm;
      else             amt[SHAMT_SRC_W-1:0] = req_rs2[SHAMT_SRC_W-1:0];
   end

   always_comb begin
      pw_d      = 5'b00000;
      log_w     = 3'd0;
      mask      = 5'd0;
      illegal_d = 1'b0;
      case (req_pw)
         3'd0: begin pw_d = 5'b00001; log_w = 3'd5; mask = 5'd31; end
         3'd1: begin pw_d = 5'b00010; log_w = 3'd4; mask = 5'd15; end
         3'd2: begin pw_d = 5'b00100; log_w = 3'd3; mask = 5'd7;  end
         3'd3: begin pw_d = 5'b01000; log_w = 3'd2; mask = 5'd3;  end
         3'd4: begin pw_d = 5'b10000; log_w = 3'd1; mask = 5'd1;  end
         default: illegal_d = 1'b1;
      endcase
   end

   // Any amount bit at or above log2(W) means the shift empties every element.
   assign too_big = |(amt >> log_w);

   always_comb begin
      crs1_d  = req_rs1;
      shamt_d = amt[4:0];
      if (illegal_d) begin
         crs1_d  = '0;
         shamt_d = '0;
      end else if (req_op[1]) begin
         shamt_d = amt[4:0] & mask;
      end else if (too_big) begin
         crs1_d  = '0;
         shamt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         crs1_q       <= '0;
         shamt_q      <= '0;
         pw_q         <= '0;
         shift_q      <= 1'b0;
         rotate_q     <= 1'b0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         s1_illegal_q <= 1'b0;
      end else if (accept) begin
         s1_valid_q   <= 1'b1;
         crs1_q       <= crs1_d;
         shamt_q      <= shamt_d;
         pw_q         <= pw_d;
         shift_q      <= ~req_op[1];
         rotate_q     <= req_op[1];
         left_q       <= ~req_op[0];
         right_q      <= req_op[0];
         s1_illegal_q <= illegal_d;
      end else if (s1_adv) begin
         s1_valid_q   <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid_q   <= 1'b0;
         result_q     <= '0;
         s2_illegal_q <= 1'b0;
      end else if (s1_adv) begin
         s2_valid_q   <= 1'b1;
         result_q     <= s1_illegal_q ? 32'h0 : shf_result;
         s2_illegal_q <= s1_illegal_q;
      end else if (rsp_ready) begin
         s2_valid_q   <= 1'b0;
      end
   end

   assign shf_crs1    = crs1_q;
   assign shf_shamt   = shamt_q;
   assign shf_pw      = pw_q;
   assign shf_shift   = shift_q;
   assign shf_rotate  = rotate_q;
   assign shf_left    = left_q;
   assign shf_right   = right_q;
   assign rsp_valid   = s2_valid_q;
   assign rsp_result  = result_q;
   assign rsp_illegal = s2_illegal_q;

endmodule

// File: tb/tb_p_shfrot_issue.sv
// Scoreboard bench for p_shfrot_issue; a behavioural p_shfrot stand-in closes the shf_* loop.
module tb_p_shfrot_issue;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_rs1, req_rs2;
   logic [4:0]  req_imm;
   logic        req_use_imm;
   logic [2:0]  req_pw;
   logic [1:0]  req_op;
   logic [31:0] shf_crs1;
   logic [4:0]  shf_shamt, shf_pw;
   logic        shf_shift, shf_rotate, shf_left, shf_right;
   logic [31:0] shf_result;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_illegal;

   int checks = 0;
   int passed = 0;
   logic [32:0] sb[$];
   bit rand_bp = 1'b0;

   p_shfrot_issue #(.SHAMT_SRC_W(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .req_use_imm(req_use_imm), .req_pw(req_pw), .req_op(req_op),
      .shf_crs1(shf_crs1), .shf_shamt(shf_shamt), .shf_pw(shf_pw),
      .shf_shift(shf_shift), .shf_rotate(shf_rotate),
      .shf_left(shf_left), .shf_right(shf_right),
      .shf_result(shf_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_illegal(rsp_illegal)
   );

   always #5 clock = ~clock;

   // Element-wise packed shift/rotate straight from the operation definition.
   function automatic logic [31:0] pack_op(logic [31:0] x, int w, int amt, bit rot, bit right);
      longint unsigned m, e, r;
      logic [31:0] res;
      int k;
      res = '0;
      m = (64'd1 << w) - 1;
      for (int i = 0; i < 32 / w; i++) begin
         e = longint'(x >> (i * w)) & m;
         if (rot) begin
            k = amt % w;
            if (right) r = ((e >> k) | (e << (w - k))) & m;
            else       r = ((e << k) | (e >> (w - k))) & m;
         end else if (amt >= w) r = 0;
         else if (right)        r = e >> amt;
         else                   r = (e << amt) & m;
         res |= 32'(r) << (i * w);
      end
      return res;
   endfunction

   function automatic logic [32:0] ref_model(logic [31:0] rs1, logic [31:0] rs2, logic [4:0] imm,
                                             logic use_imm, logic [2:0] pw, logic [1:0] op);
      int amt;
      if (pw > 3'd4) return {1'b1, 32'h0};
      amt = use_imm ? int'(imm) : int'(rs2[7:0]);
      return {1'b0, pack_op(rs1, 32 >> pw, amt, op[1], op[0])};
   endfunction

   // Stand-in for the combinational p_shfrot unit.
   always_comb begin
      int w;
      case (shf_pw)
         5'b00001: w = 32;
         5'b00010: w = 16;
         5'b00100: w = 8;
         5'b01000: w = 4;
         5'b10000: w = 2;
         default:  w = 0;
      endcase
      shf_result = '0;
      if (w != 0) shf_result = pack_op(shf_crs1, w, int'(shf_shamt), shf_rotate, shf_right);
   end

   task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clock) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("unexpected_rsp", 33'd1, 33'd0);
         else chk("rsp", {rsp_illegal, rsp_result}, sb.pop_front());
      end
   end

   always @(posedge clock) begin
      #1;
      if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
   end

   // Call at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(logic [31:0] rs1, logic [31:0] rs2, logic [4:0] imm,
                       logic use_imm, logic [2:0] pw, logic [1:0] op);
      int n = 0;
      req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
      req_use_imm = use_imm; req_pw = pw; req_op = op;
      req_valid = 1'b1;
      forever begin
         @(negedge clock);
         if (req_ready) begin
            sb.push_back(ref_model(rs1, rs2, imm, use_imm, pw, op));
            break;
         end
         n++;
         if (n > 200) begin
            chk("accept_timeout", 33'd1, 33'd0);
            break;
         end
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_use_imm = 1'b0; req_pw = '0; req_op = '0;
      idle(2);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_rsp_valid", 33'(rsp_valid), 33'd0);
      chk("rst_rsp", {rsp_illegal, rsp_result}, 33'd0);
      chk("rst_shf", {shf_crs1, 1'b0} | 33'({shf_shamt, shf_pw, shf_shift, shf_rotate, shf_left, shf_right}), 33'd0);
      chk("rst_req_ready", 33'(req_ready), 33'd1);
      @(posedge clock); #1;

      // Basic shift, with latency check: valid after the edge following accept.
      send(32'h1, 32'h0, 5'd4, 1'b1, 3'd0, 2'b00);
      chk("lat_not_yet", 33'(rsp_valid), 33'd0);
      @(posedge clock); #1;
      chk("lat_valid", 33'(rsp_valid), 33'd1);
      chk("lat_result", {rsp_illegal, rsp_result}, 33'h0_0000_0010);
      idle(2);

      send(32'h80010203, 32'd9, 5'd0, 1'b0, 3'd2, 2'b11);
      chk("ror_shamt", 33'(shf_shamt), 33'd1);
      chk("ror_ctl", 33'({shf_pw, shf_shift, shf_rotate, shf_left, shf_right}), 33'b00100_0101);
      idle(2);
      chk("ror_value", 33'(32'h40800181), ref_model(32'h80010203, 32'd9, 5'd0, 1'b0, 3'd2, 2'b11));

      send(32'hFFFFFFFF, 32'd20, 5'd0, 1'b0, 3'd1, 2'b01);
      chk("oob_crs1", 33'(shf_crs1), 33'd0);
      chk("oob_shamt", 33'(shf_shamt), 33'd0);
      idle(2);

      // Backpressure: A and B fill the pipe, C stalls until the consumer drains.
      rsp_ready = 1'b0;
      send(32'hA5A5A5A5, 32'd3, 5'd0, 1'b0, 3'd1, 2'b10);
      send(32'h0F0F0F0F, 32'd0, 5'd2, 1'b1, 3'd3, 2'b01);
      req_rs1 = 32'hDEADBEEF; req_rs2 = 32'd7; req_imm = 5'd0;
      req_use_imm = 1'b0; req_pw = 3'd2; req_op = 2'b00; req_valid = 1'b1;
      @(negedge clock);
      chk("bp_stall1", 33'(req_ready), 33'd0);
      @(negedge clock);
      chk("bp_stall2", 33'(req_ready), 33'd0);
      @(posedge clock); #1;
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp_rsp_a", 33'(rsp_valid), 33'd1);
      chk("bp_accept_c", 33'(req_ready), 33'd1);
      sb.push_back(ref_model(32'hDEADBEEF, 32'd7, 5'd0, 1'b0, 3'd2, 2'b00));
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(negedge clock);
      chk("bp_rsp_b", 33'(rsp_valid), 33'd1);
      @(negedge clock);
      chk("bp_rsp_c", 33'(rsp_valid), 33'd1);
      @(posedge clock); #1;

      // Illegal width followed by a legal request.
      send(32'h12345678, 32'd0, 5'd3, 1'b1, 3'd6, 2'b10);
      chk("ill_pw", 33'(shf_pw), 33'd0);
      chk("ill_crs1", 33'(shf_crs1), 33'd0);
      send(32'h12345678, 32'd0, 5'd1, 1'b1, 3'd3, 2'b00);
      idle(3);
      chk("nib_value", ref_model(32'h12345678, 32'd0, 5'd1, 1'b1, 3'd3, 2'b00), 33'h0_2468ACE0);

      // Reset with both stages full must drop everything in flight.
      rsp_ready = 1'b0;
      send(32'h11111111, 32'd1, 5'd0, 1'b0, 3'd0, 2'b00);
      send(32'h22222222, 32'd2, 5'd0, 1'b0, 3'd0, 2'b00);
      idle(1);
      reset = 1'b1;
      sb.delete();
      idle(1);
      reset = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("rr_rsp_valid", 33'(rsp_valid), 33'd0);
      chk("rr_req_ready", 33'(req_ready), 33'd1);
      @(posedge clock); #1;
      idle(6);

      // Randomised traffic under random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [2:0] pw;
         pw = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         send($urandom, $urandom_range(0, 255) | ($urandom & 32'hFFFFFF00),
              5'($urandom), 1'($urandom), pw, 2'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_bp = 1'b0;
      idle(1);
      rsp_ready = 1'b1;
      for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
      chk("drain", 33'(sb.size()), 33'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
